// File: rtl/audio_pkg.sv
// Shared constants, FSM state encoding and the gain-scaling helper for the codec feeder.
// Used by audio_codec_feeder and decay_envelope (the latter only under AUDIO_DECAY_ENVELOPE_EN).
package audio_pkg;

   localparam int SAMPLE_W = 32;
   localparam int GAIN_W = 8;
   localparam logic [GAIN_W-1:0] GAIN_FULL = 8'd255;
   localparam int SAMPLE_DIV_DEFAULT = 1042;
   localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      WRITE = 2'd2
   } feeder_state_e;

   // Gain is treated as unsigned 0..255; the arithmetic shift floors toward minus infinity.
   function automatic logic signed [SAMPLE_W-1:0] scale_sample(
      input logic signed [SAMPLE_W-1:0] sample,
      input logic [GAIN_W-1:0] gain
   );
      logic signed [PROD_W-1:0] prod;
      prod = $signed({{(PROD_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample}) *
             $signed({{(PROD_W-GAIN_W){1'b0}}, gain});
      return prod[SAMPLE_W+7:8];
   endfunction

endpackage

// File: rtl/decay_envelope.sv
// Music-box decay envelope: restarts at full gain on note onset and steps down every DECAY_STEP ticks.
// Only compiled when AUDIO_DECAY_ENVELOPE_EN is defined.
`ifdef AUDIO_DECAY_ENVELOPE_EN
module decay_envelope
   import audio_pkg::*;
#(
   parameter int DECAY_STEP  = 2400,
   parameter int DECAY_SHIFT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              tick,
   input  logic              note_start,
   output logic [GAIN_W-1:0] gain
);

   localparam int STEP_W = (DECAY_STEP > 1) ? $clog2(DECAY_STEP) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DECAY_STEP - 1);

   logic [GAIN_W-1:0] gain_q, gain_d;
   logic [GAIN_W-1:0] shr_s, dec_s;
   logic [STEP_W-1:0] step_q, step_d;

   assign shr_s = gain_q >> DECAY_SHIFT;
   assign dec_s = (shr_s == '0) ? GAIN_W'(1) : shr_s;
   assign gain  = gain_q;

   // Onset wins over a decrement landing in the same cycle; gain saturates at zero.
   always_comb begin
      gain_d = gain_q;
      step_d = step_q;
      if (note_start) begin
         gain_d = GAIN_FULL;
         step_d = '0;
      end else if (tick) begin
         if (step_q == STEP_LAST) begin
            step_d = '0;
            gain_d = (gain_q > dec_s) ? (gain_q - dec_s) : '0;
         end else begin
            step_d = step_q + STEP_W'(1);
         end
      end else begin
         step_d = step_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gain_q <= '0;
         step_q <= '0;
      end else begin
         gain_q <= gain_d;
         step_q <= step_d;
      end
   end

endmodule
`endif

// File: rtl/audio_codec_feeder.sv
// Decimates the generator waveform to the codec rate and feeds the codec FIFO handshake.
// AUDIO_DECAY_ENVELOPE_EN adds the decay envelope; otherwise samples pass through unscaled.
module audio_codec_feeder
   import audio_pkg::*;
#(
   parameter int SAMPLE_DIV  = SAMPLE_DIV_DEFAULT,
   parameter int DECAY_STEP  = 2400,
   parameter int DECAY_SHIFT = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       play_note,
   input  logic                       note_start,
   input  logic signed [SAMPLE_W-1:0] audio_in,
   input  logic                       audio_out_allowed,
   output logic                       write_audio_out,
   output logic signed [SAMPLE_W-1:0] left_channel_audio_out,
   output logic signed [SAMPLE_W-1:0] right_channel_audio_out,
   output logic [7:0]                 overrun_count
);

   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

   feeder_state_e state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic pending_q, pending_d;
   logic write_q, write_d;
   logic [7:0] overrun_q, overrun_d;
   logic signed [SAMPLE_W-1:0] hold_q, hold_d;
   logic signed [SAMPLE_W-1:0] chan_q, chan_d;
   logic signed [SAMPLE_W-1:0] scaled_s;
   logic tick_s, writing_s;

   assign tick_s    = (div_cnt_q == DIV_LAST);
   assign writing_s = (state_q == WRITE);

`ifdef AUDIO_DECAY_ENVELOPE_EN
   logic [GAIN_W-1:0] gain_s;

   decay_envelope #(
      .DECAY_STEP (DECAY_STEP),
      .DECAY_SHIFT(DECAY_SHIFT)
   ) u_envelope (
      .clock     (clock),
      .reset     (reset),
      .tick      (tick_s),
      .note_start(note_start),
      .gain      (gain_s)
   );

   assign scaled_s = scale_sample(audio_in, gain_s);
`else
   logic unused_cfg_s;
   assign unused_cfg_s = ^{note_start, 32'(DECAY_STEP), 32'(DECAY_SHIFT)};
   assign scaled_s = audio_in;
`endif

   // A tick during the write cycle re-arms pending without counting as an overrun.
   always_comb begin
      div_cnt_d = tick_s ? '0 : (div_cnt_q + DIV_W'(1));
      pending_d = pending_q;
      hold_d    = hold_q;
      overrun_d = overrun_q;
      chan_d    = chan_q;
      state_d   = state_q;
      if (tick_s) begin
         pending_d = 1'b1;
         hold_d    = play_note ? scaled_s : '0;
         if (pending_q && !writing_s && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
         end else begin
            overrun_d = overrun_q;
         end
      end else if (writing_s) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end

      case (state_q)
         IDLE: begin
            state_d = pending_d ? WAIT : IDLE;
         end
         WAIT: begin
            if (audio_out_allowed) begin
               state_d = WRITE;
               chan_d  = hold_q;
            end else begin
               state_d = WAIT;
            end
         end
         WRITE: begin
            state_d = pending_d ? WAIT : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      write_d = (state_d == WRITE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         div_cnt_q <= '0;
         pending_q <= 1'b0;
         write_q   <= 1'b0;
         overrun_q <= 8'd0;
         hold_q    <= '0;
         chan_q    <= '0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         pending_q <= pending_d;
         write_q   <= write_d;
         overrun_q <= overrun_d;
         hold_q    <= hold_d;
         chan_q    <= chan_d;
      end
   end

   assign write_audio_out         = write_q;
   assign left_channel_audio_out  = chan_q;
   assign right_channel_audio_out = chan_q;
   assign overrun_count           = overrun_q;

endmodule

// File: tb/tb_audio_codec_feeder.sv
// Directed bench for audio_codec_feeder; envelope scenarios run when AUDIO_DECAY_ENVELOPE_EN is defined.
module tb_audio_codec_feeder;

   localparam int D  = 8;
   localparam int DS = 4;
   localparam int SH = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic play_note = 1'b0;
   logic note_start = 1'b0;
   logic allowed = 1'b0;
   logic signed [31:0] audio_in = 32'sd0;
   logic write_audio_out;
   logic signed [31:0] left_out, right_out;
   logic [7:0] overrun_count;

   int total = 0;
   int bad = 0;
   logic signed [31:0] wr_l[$];
   logic signed [31:0] wr_r[$];
   logic signed [31:0] vals[4] = '{-32'sd1, 32'sh7FFFFFFF, 32'sh80000000, 32'sd12345};

   always #5 clock = ~clock;

   audio_codec_feeder #(
      .SAMPLE_DIV (D),
      .DECAY_STEP (DS),
      .DECAY_SHIFT(SH)
   ) dut (
      .clock                  (clock),
      .reset                  (reset),
      .play_note              (play_note),
      .note_start             (note_start),
      .audio_in               (audio_in),
      .audio_out_allowed      (allowed),
      .write_audio_out        (write_audio_out),
      .left_channel_audio_out (left_out),
      .right_channel_audio_out(right_out),
      .overrun_count          (overrun_count)
   );

   always @(negedge clock) begin
      if (write_audio_out === 1'b1) begin
         wr_l.push_back(left_out);
         wr_r.push_back(right_out);
      end
   end

   function automatic logic signed [31:0] exp_flat(input logic signed [31:0] x);
`ifdef AUDIO_DECAY_ENVELOPE_EN
      return 32'sd0;   // gain is 0 after reset until a note_start
`else
      return x;
`endif
   endfunction

   task automatic nclk(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic clear_q();
      wr_l.delete();
      wr_r.delete();
   endtask

   task automatic wait_write(input int limit);
      int n = 0;
      while (write_audio_out !== 1'b1 && n < limit) begin
         nclk(1);
         n++;
      end
      total++;
      if (write_audio_out !== 1'b1) begin
         bad++;
         $display("FAIL wait_write: write_audio_out=%b after %0d cycles, required 1", write_audio_out, n);
      end
   endtask

   task automatic collect(input int cnt, input int limit);
      int n = 0;
      while (wr_l.size() < cnt && n < limit) begin
         nclk(1);
         n++;
      end
      total++;
      if (wr_l.size() < cnt) begin
         bad++;
         $display("FAIL collect: got %0d writes, required %0d", wr_l.size(), cnt);
      end
   endtask

   task automatic test_reset();
      audio_in = 32'sd1000; play_note = 1'b1; allowed = 1'b1; reset = 1'b1;
      nclk(2);
      total++; if (write_audio_out !== 1'b0) begin bad++; $display("FAIL reset_write: got %b required 0", write_audio_out); end
      total++; if (left_out !== 32'sd0) begin bad++; $display("FAIL reset_left: got %0d required 0", left_out); end
      total++; if (right_out !== 32'sd0) begin bad++; $display("FAIL reset_right: got %0d required 0", right_out); end
      total++; if (overrun_count !== 8'd0) begin bad++; $display("FAIL reset_overrun: got %0d required 0", overrun_count); end
      reset = 1'b0;
      clear_q();
      nclk(D);
      total++; if (write_audio_out !== 1'b0) begin bad++; $display("FAIL first_early: got %b required 0", write_audio_out); end
      nclk(1);
      total++; if (write_audio_out !== 1'b1) begin bad++; $display("FAIL first_write: got %b required 1", write_audio_out); end
      total++; if (left_out !== exp_flat(32'sd1000)) begin bad++; $display("FAIL first_left: got %0d required %0d", left_out, exp_flat(32'sd1000)); end
      total++; if (right_out !== exp_flat(32'sd1000)) begin bad++; $display("FAIL first_right: got %0d required %0d", right_out, exp_flat(32'sd1000)); end
      nclk(1);
      total++; if (write_audio_out !== 1'b0) begin bad++; $display("FAIL strobe_width: got %b required 0", write_audio_out); end
      nclk(D - 2);
      total++; if (write_audio_out !== 1'b0) begin bad++; $display("FAIL spacing_early: got %b required 0", write_audio_out); end
      nclk(1);
      total++; if (write_audio_out !== 1'b1) begin bad++; $display("FAIL spacing_write: got %b required 1", write_audio_out); end
   endtask

   // Entered on the cycle of a write; each period carries a new value.
   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         audio_in = vals[i];
         nclk(D);
         total++; if (write_audio_out !== 1'b1) begin bad++; $display("FAIL b2b_write[%0d]: got %b required 1", i, write_audio_out); end
         total++; if (left_out !== exp_flat(vals[i])) begin bad++; $display("FAIL b2b_left[%0d]: got %0d required %0d", i, left_out, exp_flat(vals[i])); end
         total++; if (right_out !== exp_flat(vals[i])) begin bad++; $display("FAIL b2b_right[%0d]: got %0d required %0d", i, right_out, exp_flat(vals[i])); end
      end
   endtask

   task automatic test_play_off();
      play_note = 1'b0; audio_in = 32'sd5000;
      for (int i = 0; i < 2; i++) begin
         nclk(D - 1);
         total++; if (write_audio_out !== 1'b0) begin bad++; $display("FAIL mute_early[%0d]: got %b required 0", i, write_audio_out); end
         nclk(1);
         total++; if (write_audio_out !== 1'b1) begin bad++; $display("FAIL mute_write[%0d]: got %b required 1", i, write_audio_out); end
         total++; if (left_out !== 32'sd0) begin bad++; $display("FAIL mute_left[%0d]: got %0d required 0", i, left_out); end
      end
      play_note = 1'b1;
   endtask

   task automatic test_overrun();
      logic signed [31:0] last;
      allowed = 1'b0; reset = 1'b1;
      nclk(2);
      reset = 1'b0;
      clear_q();
      audio_in = 32'sd11;
      nclk(D);
      audio_in = 32'sd22;
      nclk(D);
      audio_in = 32'sd33;
      nclk(D);
      total++; if (overrun_count !== 8'd2) begin bad++; $display("FAIL overrun_count: got %0d required 2", overrun_count); end
      total++; if (wr_l.size() != 0) begin bad++; $display("FAIL overrun_blocked: got %0d writes required 0", wr_l.size()); end
      allowed = 1'b1;
      nclk(D - 2);
      last = (wr_l.size() > 0) ? wr_l[wr_l.size()-1] : 32'sdx;
      total++; if (wr_l.size() != 1) begin bad++; $display("FAIL release_writes: got %0d required 1", wr_l.size()); end
      total++; if (last !== exp_flat(32'sd33)) begin bad++; $display("FAIL release_data: got %0d required %0d", last, exp_flat(32'sd33)); end
      total++; if (overrun_count !== 8'd2) begin bad++; $display("FAIL overrun_hold: got %0d required 2", overrun_count); end
   endtask

   // Continues from test_overrun, which leaves the next write three cycles away.
   task automatic test_reset_during_write();
      nclk(3);
      total++; if (write_audio_out !== 1'b1) begin bad++; $display("FAIL rdw_strobe: got %b required 1", write_audio_out); end
      reset = 1'b1;
      #1;
      total++; if (write_audio_out !== 1'b0) begin bad++; $display("FAIL rdw_async: got %b required 0", write_audio_out); end
      nclk(1);
      reset = 1'b0;
      clear_q();
      nclk(1);
      total++; if (overrun_count !== 8'd0) begin bad++; $display("FAIL rdw_overrun: got %0d required 0", overrun_count); end
      total++; if (left_out !== 32'sd0) begin bad++; $display("FAIL rdw_left: got %0d required 0", left_out); end
      total++; if (right_out !== 32'sd0) begin bad++; $display("FAIL rdw_right: got %0d required 0", right_out); end
      nclk(D - 2);
      total++; if (wr_l.size() != 0) begin bad++; $display("FAIL rdw_discard: got %0d writes required 0", wr_l.size()); end
   endtask

`ifdef AUDIO_DECAY_ENVELOPE_EN
   task automatic pulse_note();
      note_start = 1'b1;
      nclk(1);
      note_start = 1'b0;
      clear_q();
   endtask

   task automatic test_decay_start();
      logic signed [31:0] exp_v[6] = '{-32'sd25500, -32'sd25500, -32'sd25500, -32'sd25500, -32'sd24000, -32'sd24000};
      audio_in = -32'sd25600;
      wait_write(3 * D);
      pulse_note();
      collect(6, 8 * D);
      for (int i = 0; i < 6 && i < wr_l.size(); i++) begin
         total++; if (wr_l[i] !== exp_v[i]) begin bad++; $display("FAIL decay_left[%0d]: got %0d required %0d", i, wr_l[i], exp_v[i]); end
         total++; if (wr_r[i] !== exp_v[i]) begin bad++; $display("FAIL decay_right[%0d]: got %0d required %0d", i, wr_r[i], exp_v[i]); end
      end
   endtask

   // audio_in = 256 makes each written sample equal to the gain used for it.
   task automatic test_decay_floor();
      int g = 255;
      int c = 0;
      int dec;
      audio_in = 32'sd256;
      wait_write(3 * D);
      pulse_note();
      collect(320, 330 * D);
      for (int i = 0; i < 320 && i < wr_l.size(); i++) begin
         total++; if (wr_l[i] !== 32'(g)) begin bad++; $display("FAIL floor[%0d]: got %0d required %0d", i, wr_l[i], g); end
         c++;
         if (c == DS) begin
            c = 0;
            dec = g >> SH;
            if (dec == 0) dec = 1;
            g = (g > dec) ? g - dec : 0;
         end
      end
      total++; if (g != 0) begin bad++; $display("FAIL floor_model: got %0d required 0", g); end
   endtask

   task automatic test_note_on_decrement();
      logic signed [31:0] exp_v[6] = '{32'sd255, 32'sd255, 32'sd255, 32'sd255, 32'sd255, 32'sd240};
      audio_in = 32'sd256;
      wait_write(3 * D);
      pulse_note();
      collect(3, 4 * D);
      nclk(D - 2);
      pulse_note();
      collect(6, 8 * D);
      for (int i = 0; i < 6 && i < wr_l.size(); i++) begin
         total++; if (wr_l[i] !== exp_v[i]) begin bad++; $display("FAIL note_prio[%0d]: got %0d required %0d", i, wr_l[i], exp_v[i]); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_play_off();
      test_overrun();
      test_reset_during_write();
`ifdef AUDIO_DECAY_ENVELOPE_EN
      test_decay_start();
      test_decay_floor();
      test_note_on_decrement();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/audio_codec_feeder.md
# audio_codec_feeder

Sits directly downstream of the per-note waveform generators, between the generator's 32-bit signed `audio_out` and the board audio codec's sample FIFO. Decimates the generator's per-clock waveform to a fixed codec sample rate and applies the music-box decay gain. Drives both codec channels with the same sample through the codec's `audio_out_allowed` / `write_audio_out` handshake, and counts samples lost to FIFO back-pressure.

## Interface
Parameters:
- `SAMPLE_DIV`, 1042: clocks per codec sample; 50 MHz / 1042 ≈ 48 kHz. Legal range is ≥ 4.
- `DECAY_STEP`, 2400: codec samples between envelope decrements.
- `DECAY_SHIFT`, 4: envelope decrement is `max(1, gain >> DECAY_SHIFT)`.

Ports:
- `clock`, in, 1: single system clock.
- `reset`, in, 1: asynchronous, active-high.
- `play_note`, in, 1: a note is sounding; when low, the captured sample is 0.
- `note_start`, in, 1: one-cycle pulse at note onset; restarts the envelope.
- `audio_in`, in, 32: signed waveform from the generator.
- `audio_out_allowed`, in, 1: codec FIFO has space.
- `write_audio_out`, out, 1: one-cycle write strobe to the codec.
- `left_channel_audio_out`, out, 32: signed sample.
- `right_channel_audio_out`, out, 32: identical to left.
- `overrun_count`, out, 8: saturating count of overwritten samples.

## Operation
- **Tick counter:** `div_cnt` counts 0..SAMPLE_DIV-1 and wraps. `tick` is asserted when `div_cnt == SAMPLE_DIV-1`.
- **Capture:** on `tick`, `hold <= play_note ? scaled(audio_in) : 0` and `pending <= 1`.
- **Overrun:** a tick while `pending == 1` and no write is occurring that cycle overwrites `hold` and increments `overrun_count`, which saturates at 255.
- **FSM states:**
  - IDLE: on `pending`, go to WAIT.
  - WAIT: on `audio_out_allowed == 1`, go to WRITE and latch `hold` onto both channel outputs.
  - WRITE: `write_audio_out = 1` for exactly one cycle. Clear `pending`, unless a tick arrives the same cycle, in which case the new sample stays pending with no overrun. Next state is WAIT if `pending` is still set, otherwise IDLE.
- Channel outputs hold their value between writes.
- **Arithmetic:** `scaled = (audio_in * $signed({1'b0,gain})) >>> 8`. Use a 41-bit signed product, keep bits [39:8], truncate toward −∞. Gain 255 yields `audio_in * 255/256`.
- **Envelope:** `gain` is 8-bit unsigned and resets to 0.
  - `note_start` sets `gain` to 255 and clears the step counter. It has priority over a decrement in the same cycle.
  - Every DECAY_STEP ticks, `gain -= max(1, gain >> DECAY_SHIFT)`, floored at 0. `gain` never wraps.

## Timing
- Reset values: `write_audio_out = 0`, both channels 0, `overrun_count = 0`, state IDLE, `div_cnt = 0`, `pending = 0`, `gain = 0`.
- Latency: with `tick` at cycle T, `hold` is valid at T+1 and the FSM is in WAIT at T+1.
  - If `audio_out_allowed` is high at T+1, `write_audio_out` is high at T+2 with data valid the same cycle.
  - Otherwise the write occurs the cycle after `audio_out_allowed` is first sampled high.
- `audio_out_allowed` dropping during WRITE does not cancel the strobe; the codec samples it in that cycle.
- Reset asserted mid-operation clears `write_audio_out` immediately (asynchronously). Pending data is discarded.
- Minimum spacing between write strobes is SAMPLE_DIV cycles in steady state.

## Configuration
- `AUDIO_DECAY_ENVELOPE_EN` defined: the envelope logic is built as described above.
- Not defined: the envelope and step counter are not instantiated.
  - `scaled(audio_in) = audio_in`, passed through unchanged.
  - `note_start` is ignored.
  - DECAY_STEP and DECAY_SHIFT are unused.

## Structure
- A shared package `audio_pkg` holds:
  - `SAMPLE_W = 32`;
  - `GAIN_W = 8`;
  - `GAIN_FULL = 8'd255`;
  - the FSM state enum (IDLE, WAIT, WRITE);
  - the default `SAMPLE_DIV` constant for the 50 MHz clock.
- One sub-module, `decay_envelope`, owns `gain`, the step counter and the decrement rule. Inputs are `tick` and `note_start`; output is `gain`. It is instantiated only under `AUDIO_DECAY_ENVELOPE_EN`.

## Test plan
- Reset with `audio_in = 1000`, `play_note = 1`, `audio_out_allowed = 1`, macro off → first `write_audio_out` at cycle SAMPLE_DIV+1 after release; both channels 1000; strobe width 1.
- Macro on, `note_start` pulse, `audio_in = -25600` → first written sample −25500. After DECAY_STEP ticks, gain is 240 and the sample is −24000.
- Hold `audio_out_allowed = 0` for 3·SAMPLE_DIV cycles → `overrun_count = 2`. On release, exactly one write of the latest sample.
- `play_note = 0` with `audio_in = 5000` → written samples are 0 and the cadence is unchanged.
- Decay to floor: gain reaches 0 and stays 0; no wrap. A `note_start` coinciding with a decrement tick yields 255.
- Reset asserted during the WRITE cycle → `write_audio_out` low within the same cycle. After release, `overrun_count = 0` and the channels read 0.
